// File: rtl/icw_ocw_decoder.sv
// rtl/icw_ocw_decoder.sv - 8259 ICW1-ICW4 init sequencer and OCW1-OCW3 command decoder
// A CPU write commits on the first clk edge that sees WR_n low with CS_n low.
module icw_ocw_decoder #(
   parameter logic [7:0] IMR_RESET = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CS_n,
   input  logic       WR_n,
   input  logic       A0,
   input  logic [7:0] DIN,
   output logic [7:0] OCW1,
   output logic [4:0] VEC_ADD,
   output logic       EOI_mode,
   output logic       read_mode,
   output logic [2:0] int_level,
   output logic [2:0] EOI_command,
   output logic       ocw2_valid,
   output logic       poll_cmd,
   output logic       special_mask,
   output logic       single_mode,
   output logic       level_trig,
   output logic [7:0] cascade_cfg,
   output logic       sfnm,
   output logic       init_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ICW2,
      S_ICW3,
      S_ICW4,
      S_READY
   } state_t;

   state_t r_state;
   logic   r_wr_prev;
   logic   r_ic4;

   logic   w_commit;
   logic   w_icw1;

   // r_wr_prev follows WR_n regardless of CS_n, so a held strobe never re-commits
   assign w_commit = !CS_n && !WR_n && r_wr_prev;
   assign w_icw1   = !A0 && DIN[4];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wr_prev    <= 1'b1;
         r_ic4        <= 1'b0;
         OCW1         <= IMR_RESET;
         VEC_ADD      <= 5'd0;
         EOI_mode     <= 1'b0;
         read_mode    <= 1'b0;
         int_level    <= 3'd0;
         EOI_command  <= 3'd0;
         ocw2_valid   <= 1'b0;
         poll_cmd     <= 1'b0;
         special_mask <= 1'b0;
         single_mode  <= 1'b0;
         level_trig   <= 1'b0;
         cascade_cfg  <= 8'd0;
         sfnm         <= 1'b0;
         init_done    <= 1'b0;
      end else begin
         r_wr_prev  <= WR_n;
         ocw2_valid <= 1'b0;
         poll_cmd   <= 1'b0;
         if (w_commit) begin
            if (w_icw1) begin
               r_ic4        <= DIN[0];
               single_mode  <= DIN[1];
               level_trig   <= DIN[3];
               OCW1         <= 8'h00;
               read_mode    <= 1'b0;
               special_mask <= 1'b0;
               EOI_mode     <= 1'b0;
               sfnm         <= 1'b0;
               cascade_cfg  <= 8'h00;
               init_done    <= 1'b0;
               r_state      <= S_ICW2;
            end else begin
               case (r_state)
                  S_ICW2: if (A0) begin
                     VEC_ADD <= DIN[7:3];
                     if (!single_mode) begin
                        r_state <= S_ICW3;
                     end else if (r_ic4) begin
                        r_state <= S_ICW4;
                     end else begin
                        r_state   <= S_READY;
                        init_done <= 1'b1;
                     end
                  end
                  S_ICW3: if (A0) begin
                     cascade_cfg <= DIN;
                     if (r_ic4) begin
                        r_state <= S_ICW4;
                     end else begin
                        r_state   <= S_READY;
                        init_done <= 1'b1;
                     end
                  end
                  S_ICW4: if (A0) begin
                     EOI_mode  <= DIN[1];
                     sfnm      <= DIN[4];
                     r_state   <= S_READY;
                     init_done <= 1'b1;
                  end
                  S_READY: begin
                     if (A0) begin
                        OCW1 <= DIN;
                     end else if (DIN[4:3] == 2'b00) begin
                        EOI_command <= DIN[7:5];
                        int_level   <= DIN[2:0];
                        ocw2_valid  <= 1'b1;
                     end else begin
                        // only 2'b01 can reach here: DIN[4]=1 was taken as ICW1
                        if (DIN[1]) read_mode <= DIN[0];
                        if (DIN[6]) special_mask <= DIN[5];
                        if (DIN[2]) poll_cmd <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
